// File: rtl/dmem_loader_pkg.sv
// dmem_loader_pkg: constants and FSM state type shared by the data-memory
// loader, the CPU and the DMEM.
//   DMEM_NWORDS : number of preset words loaded at boot
//   DMEM_AW     : DMEM address width
//   DMEM_DW     : DMEM data width
//   state_t     : loader FSM states
package dmem_loader_pkg;

    localparam int DMEM_NWORDS = 8;
    localparam int DMEM_AW     = 3;
    localparam int DMEM_DW     = 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD,
        CMP,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/dmem_loader.sv
// dmem_loader: boot-time data-memory initialiser. On start it snapshots the
// eight preset bytes, writes them to DMEM addresses 0..7, optionally reads
// them back and compares, and holds the CPU stalled until a good load ends.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           single-cycle load request
//   D0..D7          preset bytes
//   mem_addr/mem_wdata/mem_we  DMEM write/read port
//   mem_rdata       DMEM read data (one cycle after mem_addr)
//   cpu_hold        CPU stall, released only on DONE
//   busy            high in WRITE, RD and CMP
//   done, err       successful completion / verify mismatch
//   err_addr        address of the first mismatching word
module dmem_loader
    import dmem_loader_pkg::*;
#(
    parameter int NWORDS = DMEM_NWORDS,
    parameter int AW     = DMEM_AW,
    parameter int DW     = DMEM_DW,
    parameter bit VERIFY = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] D0,
    input  logic [DW-1:0] D1,
    input  logic [DW-1:0] D2,
    input  logic [DW-1:0] D3,
    input  logic [DW-1:0] D4,
    input  logic [DW-1:0] D5,
    input  logic [DW-1:0] D6,
    input  logic [DW-1:0] D7,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] err_addr
);

    localparam logic [AW-1:0] LAST = AW'(NWORDS - 1);

    state_t        state, state_n;
    logic [AW-1:0] k, k_n;
    logic [DW-1:0] snap   [NWORDS];
    logic [DW-1:0] snap_n [NWORDS];
    logic [DW-1:0] din    [NWORDS];
    logic          bad_seen, bad_seen_n;
    logic [AW-1:0] err_addr_n;
    logic [AW-1:0] cmp_idx;
    logic          mismatch;

    logic [AW-1:0] mem_addr_n;
    logic [DW-1:0] mem_wdata_n;
    logic          mem_we_n, cpu_hold_n, busy_n, done_n, err_n;

    always_comb begin
        din         = '{D0, D1, D2, D3, D4, D5, D6, D7};
        state_n     = state;
        k_n         = k;
        snap_n      = snap;
        bad_seen_n  = bad_seen;
        err_addr_n  = err_addr;

        // Read data lags the address by one cycle, so RD cycle k checks
        // word k-1 and the CMP drain cycle checks the last word.
        cmp_idx  = (state == CMP) ? LAST : k - AW'(1);
        mismatch = ((state == RD && k != '0) || state == CMP) &&
                   (mem_rdata != snap[cmp_idx]);

        unique case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_n    = WRITE;
                    k_n        = '0;
                    snap_n     = din;
                    bad_seen_n = 1'b0;
                    err_addr_n = '0;
                end
            end
            WRITE: begin
                if (k == LAST) begin
                    k_n     = '0;
                    state_n = VERIFY ? RD : DONE;
                end else begin
                    k_n = k + AW'(1);
                end
            end
            RD: begin
                if (k == LAST) state_n = CMP;
                else           k_n     = k + AW'(1);
            end
            CMP: begin
                state_n = (bad_seen || mismatch) ? ERROR : DONE;
            end
            default: state_n = IDLE;
        endcase

        if (mismatch && !bad_seen) begin
            bad_seen_n = 1'b1;
            err_addr_n = cmp_idx;
        end

        // Outputs are decoded from the next state and registered, so every
        // output comes straight from a flop.
        mem_we_n    = (state_n == WRITE);
        mem_addr_n  = (state_n == WRITE || state_n == RD) ? k_n : '0;
        mem_wdata_n = (state_n == WRITE) ? snap_n[k_n] : '0;
        busy_n      = (state_n == WRITE || state_n == RD || state_n == CMP);
        done_n      = (state_n == DONE);
        err_n       = (state_n == ERROR);
        cpu_hold_n  = (state_n != DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            snap      <= '{default: '0};
            bad_seen  <= 1'b0;
            err_addr  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            cpu_hold  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            k         <= k_n;
            snap      <= snap_n;
            bad_seen  <= bad_seen_n;
            err_addr  <= err_addr_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            mem_we    <= mem_we_n;
            cpu_hold  <= cpu_hold_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

endmodule

// File: tb/tb_dmem_loader.sv
// tb_dmem_loader: directed bench for dmem_loader with a synchronous-read
// DMEM model that can force selected addresses to read back 0xFF.
module tb_dmem_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7;

    logic [2:0] mem_addr, err_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic       mem_we, cpu_hold, busy, done, err;

    logic [2:0] nv_addr, nv_err_addr;
    logic [7:0] nv_wdata;
    logic       nv_we, nv_hold, nv_busy, nv_done, nv_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [8];
    logic [7:0] bad_mask = 8'h00;
    int         wr_n = 0;
    logic [2:0] log_a [128];
    logic [7:0] log_d [128];
    logic [7:0] exp_d [8];

    always #5 clk = ~clk;

    dmem_loader #(.VERIFY(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .D0(d0), .D1(d1), .D2(d2), .D3(d3), .D4(d4), .D5(d5), .D6(d6), .D7(d7),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .busy(busy),
        .done(done), .err(err), .err_addr(err_addr)
    );

    dmem_loader #(.VERIFY(1'b0)) u_nv (
        .clk(clk), .rst(rst), .start(start),
        .D0(d0), .D1(d1), .D2(d2), .D3(d3), .D4(d4), .D5(d5), .D6(d6), .D7(d7),
        .mem_addr(nv_addr), .mem_wdata(nv_wdata), .mem_we(nv_we),
        .mem_rdata(8'h00), .cpu_hold(nv_hold), .busy(nv_busy),
        .done(nv_done), .err(nv_err), .err_addr(nv_err_addr)
    );

    // DMEM model: logs every write, read data registered one cycle after
    // the address, addresses flagged in bad_mask read back as 0xFF.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            log_a[wr_n]   <= mem_addr;
            log_d[wr_n]   <= mem_wdata;
            wr_n          <= wr_n + 1;
        end
        mem_rdata <= bad_mask[mem_addr] ? 8'hFF : mem[mem_addr];
    end

    task automatic check(input string tag, input int got, input int expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, expv);
        end
    endtask

    task automatic set_preset(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7);
        {d0, d1, d2, d3, d4, d5, d6, d7} = {a0, a1, a2, a3, a4, a5, a6, a7};
        exp_d = '{a0, a1, a2, a3, a4, a5, a6, a7};
    endtask

    // Start at edge t, run to just after edge t+17 (first cycle of DONE or
    // ERROR). chg_at: cycle index at which D0 becomes 0x55; p1/p2: cycles
    // at which start is pulsed again; chk_nv: check the VERIFY=0 instance.
    task automatic run_load(input string name, input int chg_at,
                            input int p1, input int p2, input bit chk_nv);
        int base;
        @(negedge clk);
        base  = wr_n;
        start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            start = (i == p1 || i == p2);
            if (i == chg_at) d0 = 8'h55;
            if (i == 1) begin
                check({name, ".t1_we"},      mem_we, 1);
                check({name, ".t1_addr"},    mem_addr, 0);
                check({name, ".t1_hold"},    cpu_hold, 1);
                check({name, ".t1_done"},    done, 0);
                check({name, ".t1_err"},     err, 0);
                check({name, ".t1_erraddr"}, err_addr, 0);
            end
            if (chk_nv && i == 8) check({name, ".nv_done_t8"}, nv_done, 0);
            if (chk_nv && i == 9) begin
                check({name, ".nv_done_t9"}, nv_done, 1);
                check({name, ".nv_hold_t9"}, nv_hold, 0);
            end
            if (i == 9)  check({name, ".rd_we"}, mem_we, 0);
            if (i == 17) begin
                check({name, ".cmp_busy"}, busy, 1);
                check({name, ".cmp_done"}, done, 0);
                check({name, ".cmp_hold"}, cpu_hold, 1);
            end
            @(posedge clk);
        end
        #1;
        check({name, ".wr_count"}, wr_n - base, 8);
        for (int j = 0; j < 8; j++) begin
            check($sformatf("%s.wr%0d_addr", name, j), log_a[base + j], j);
            check($sformatf("%s.wr%0d_data", name, j), log_d[base + j], exp_d[j]);
        end
    endtask

    initial begin
        set_preset(8'h0A, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("rst.hold",  cpu_hold, 1);
        check("rst.busy",  busy, 0);
        check("rst.done",  done, 0);
        check("rst.err",   err, 0);
        check("rst.we",    mem_we, 0);
        check("rst.addr",  mem_addr, 0);
        check("rst.wdata", mem_wdata, 0);
        check("rst.eaddr", err_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        // Clean load with verify.
        run_load("basic", -1, -1, -1, 1'b1);
        check("basic.done", done, 1);
        check("basic.hold", cpu_hold, 0);
        check("basic.err",  err, 0);
        check("basic.busy", busy, 0);

        // Address 3 reads back corrupted.
        set_preset(8'h22, 8'hA8, 8'h04, 8'h03, 8'h22, 8'h00, 8'h00, 8'h00);
        bad_mask = 8'b0000_1000;
        run_load("bad3", -1, -1, -1, 1'b0);
        check("bad3.err",   err, 1);
        check("bad3.eaddr", err_addr, 3);
        check("bad3.done",  done, 0);
        check("bad3.hold",  cpu_hold, 1);

        // Addresses 2 and 5 corrupted: only the first is reported.
        bad_mask = 8'b0010_0100;
        run_load("bad25", -1, -1, -1, 1'b0);
        check("bad25.err",   err, 1);
        check("bad25.eaddr", err_addr, 2);
        check("bad25.done",  done, 0);

        // D0 changes mid-load: snapshot value is written and verified.
        bad_mask = 8'h00;
        set_preset(8'h0A, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        run_load("snap", 3, -1, -1, 1'b0);
        check("snap.done", done, 1);
        check("snap.err",  err, 0);
        check("snap.hold", cpu_hold, 0);

        // Extra start pulses in WRITE and RD are ignored.
        set_preset(8'h0A, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        run_load("ign", -1, 4, 12, 1'b0);
        check("ign.done", done, 1);
        check("ign.err",  err, 0);

        // Restart from DONE: done drops on the accepting edge, full reload.
        run_load("redo", -1, -1, -1, 1'b0);
        check("redo.done", done, 1);
        check("redo.hold", cpu_hold, 0);

        // Asynchronous reset during WRITE.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("mid.we_before", mem_we, 1);
        rst = 1'b1;
        #1;
        check("mid.we",    mem_we, 0);
        check("mid.addr",  mem_addr, 0);
        check("mid.wdata", mem_wdata, 0);
        check("mid.hold",  cpu_hold, 1);
        check("mid.busy",  busy, 0);
        check("mid.done",  done, 0);
        check("mid.err",   err, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid.idle_we",   mem_we, 0);
        check("mid.idle_busy", busy, 0);
        run_load("after", -1, -1, -1, 1'b0);
        check("after.done", done, 1);
        check("after.err",  err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
